// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared types and sizing helpers for the tone/pulse synthesiser.
//   mode_e          per-channel waveform mode (OFF, SQUARE, PULSE, ONESHOT)
//   MODE_W          encoded width of mode_e
//   mix_width()     width of the weighted channel sum
//   ch_index_width() width of a channel select (never less than 1)
// ---------------------------------------------------------------------------
package tone_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_SQUARE  = 2'd1,
        MODE_PULSE   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    // Sum of num_ch amplitudes of amp_w bits: the largest sum,
    // num_ch * (2^amp_w - 1), always fits in amp_w + clog2(num_ch) bits.
    function automatic int mix_width(input int amp_w, input int num_ch);
        return amp_w + ((num_ch > 1) ? $clog2(num_ch) : 0);
    endfunction

    function automatic int ch_index_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// ---------------------------------------------------------------------------
// tone_channel
// One generator channel: a single-entry shadow config slot, the period/width
// counter, mode logic and the registered 1-bit wave.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg_we       accepted config write for this channel (one cycle)
//   cfg_mode     new mode
//   cfg_period   new period in clk cycles
//   cfg_width    new high time in clk cycles (PULSE / ONESHOT)
//   cfg_amp      new amplitude
//   trigger      one-shot start strobe
//   pending      shadow slot holds a write not yet applied
//   wave         registered channel wave
//   busy         one-shot pulse in progress
//   amp          active amplitude, used by the mixer
// ---------------------------------------------------------------------------
module tone_channel
    import tone_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int AMP_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  mode_e               cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_width,
    input  logic [AMP_W-1:0]    cfg_amp,
    input  logic                trigger,
    output logic                pending,
    output logic                wave,
    output logic                busy,
    output logic [AMP_W-1:0]    amp
);

    // Shadow slot
    mode_e               sh_mode;
    logic [PERIOD_W-1:0] sh_period;
    logic [PERIOD_W-1:0] sh_width;
    logic [AMP_W-1:0]    sh_amp;

    // Active parameters
    mode_e               act_mode;
    logic [PERIOD_W-1:0] act_period;
    logic [PERIOD_W-1:0] act_width;

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] count_d;
    logic                busy_d;
    logic                wave_d;

    logic                silent;
    logic                at_boundary;
    logic                apply_en;
    mode_e               eff_mode;
    logic [PERIOD_W-1:0] eff_width;
    logic                fire;

    // NOTE: every variable written here gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        silent      = (act_period < PERIOD_W'(2));
        at_boundary = (count == act_period - PERIOD_W'(1));

        // A pending write waits for the end of the current period so a
        // running tone never emits a truncated cycle. A silent channel has
        // no period boundary, so it takes the update at once. A one-shot
        // lets its pulse finish before changing.
        apply_en = 1'b0;
        if (pending) begin
            case (act_mode)
                MODE_OFF:     apply_en = 1'b1;
                MODE_ONESHOT: apply_en = !busy;
                default:      apply_en = silent || at_boundary;
            endcase
        end

        // An apply in the same cycle as a trigger is seen first, so the
        // trigger is qualified by the parameters that are about to load.
        eff_mode  = apply_en ? sh_mode  : act_mode;
        eff_width = apply_en ? sh_width : act_width;
        fire      = trigger && (eff_mode == MODE_ONESHOT) && (eff_width != '0);

        count_d = count;
        busy_d  = busy;
        if (fire) begin
            busy_d  = 1'b1;
            count_d = '0;
        end else if (apply_en) begin
            busy_d  = 1'b0;
            count_d = '0;
        end else begin
            case (act_mode)
                MODE_SQUARE, MODE_PULSE: begin
                    if (silent || at_boundary) count_d = '0;
                    else                       count_d = count + PERIOD_W'(1);
                end
                MODE_ONESHOT: begin
                    // Count stays frozen once the pulse has ended.
                    if (busy) begin
                        if (count == act_width - PERIOD_W'(1)) busy_d  = 1'b0;
                        else                                   count_d = count + PERIOD_W'(1);
                    end
                end
                default: count_d = '0;
            endcase
        end

        wave_d = 1'b0;
        case (act_mode)
            MODE_SQUARE:  wave_d = !silent && (count < (act_period >> 1));
            MODE_PULSE:   wave_d = !silent && (count < act_width);
            MODE_ONESHOT: wave_d = busy && (count < act_width);
            default:      wave_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow slot is reset too, not just the valid flag,
            // so a stray apply can never load unknown parameters.
            sh_mode    <= MODE_OFF;
            sh_period  <= '0;
            sh_width   <= '0;
            sh_amp     <= '0;
            act_mode   <= MODE_OFF;
            act_period <= '0;
            act_width  <= '0;
            amp        <= '0;
            pending    <= 1'b0;
            count      <= '0;
            busy       <= 1'b0;
            wave       <= 1'b0;
        end else begin
            if (cfg_we) begin
                sh_mode   <= cfg_mode;
                sh_period <= cfg_period;
                sh_width  <= cfg_width;
                sh_amp    <= cfg_amp;
            end

            if (cfg_we)        pending <= 1'b1;
            else if (apply_en) pending <= 1'b0;

            if (apply_en) begin
                act_mode   <= sh_mode;
                act_period <= sh_period;
                act_width  <= sh_width;
                amp        <= sh_amp;
            end

            count <= count_d;
            busy  <= busy_d;
            wave  <= wave_d;
        end
    end

endmodule

// File: rtl/tone_pulse_synth.sv
// ---------------------------------------------------------------------------
// tone_pulse_synth
// Multi-channel tone / pulse generator feeding a first-order sigma-delta
// modulator that drives the 1-bit speaker line.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg_valid    config write request
//   cfg_ready    write accepted when cfg_valid && cfg_ready (combinational)
//   cfg_ch       target channel
//   cfg_mode     mode_e for the target channel
//   cfg_period   period in clk cycles
//   cfg_width    high time in clk cycles (PULSE / ONESHOT)
//   cfg_amp      channel amplitude
//   trigger      per-channel one-shot start strobe
//   ch_wave      registered per-channel wave
//   busy         per-channel one-shot in progress
//   mix_out      registered amplitude-weighted sum of ch_wave
//   spk_out      PDM output
// Latency: ch_wave at t, mix_out at t+1, spk_out at t+2.
// ---------------------------------------------------------------------------
module tone_pulse_synth
    import tone_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int PERIOD_W = 32,
    parameter  int AMP_W    = 8,
    localparam int CH_W     = ch_index_width(NUM_CH),
    localparam int MIX_W    = mix_width(AMP_W, NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  mode_e               cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_width,
    input  logic [AMP_W-1:0]    cfg_amp,
    input  logic [NUM_CH-1:0]   trigger,
    output logic [NUM_CH-1:0]   ch_wave,
    output logic [NUM_CH-1:0]   busy,
    output logic [MIX_W-1:0]    mix_out,
    output logic                spk_out
);

    localparam int CH_SLOTS = 2 ** CH_W;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_num_ch_check
        $error("tone_pulse_synth: NUM_CH must be in 1..16");
    end

    if (longint'(NUM_CH) * ((longint'(1) << AMP_W) - 1) >= (longint'(1) << MIX_W)) begin : g_mix_w_check
        $error("tone_pulse_synth: MIX_W too narrow for the full-scale sum");
    end

    logic [NUM_CH-1:0]   pending;
    logic [CH_SLOTS-1:0] pending_ext;
    logic [NUM_CH-1:0]   cfg_we;
    logic [AMP_W-1:0]    ch_amp [NUM_CH];

    // Unused channel codes (NUM_CH not a power of two) read as not pending,
    // so a write to them is accepted and dropped instead of stalling.
    assign pending_ext = CH_SLOTS'(pending);
    assign cfg_ready   = !pending_ext[cfg_ch];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign cfg_we[c] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));

        tone_channel #(
            .PERIOD_W (PERIOD_W),
            .AMP_W    (AMP_W)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .cfg_we     (cfg_we[c]),
            .cfg_mode   (cfg_mode),
            .cfg_period (cfg_period),
            .cfg_width  (cfg_width),
            .cfg_amp    (cfg_amp),
            .trigger    (trigger[c]),
            .pending    (pending[c]),
            .wave       (ch_wave[c]),
            .busy       (busy[c]),
            .amp        (ch_amp[c])
        );
    end

    // Mixer: amplitude of every channel whose registered wave is high.
    logic [MIX_W-1:0] mix_sum;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_wave[i]) mix_sum = mix_sum + MIX_W'(ch_amp[i]);
        end
    end

    // First-order sigma-delta: the carry out of the accumulator is the PDM
    // bit, so the mean density of spk_out is mix_out / 2^MIX_W.
    logic [MIX_W-1:0] acc;
    logic [MIX_W:0]   sd_sum;

    assign sd_sum = {1'b0, acc} + {1'b0, mix_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_out <= '0;
            acc     <= '0;
            spk_out <= 1'b0;
        end else begin
            mix_out <= mix_sum;
            acc     <= sd_sum[MIX_W-1:0];
            spk_out <= sd_sum[MIX_W];
        end
    end

endmodule
